// File: rtl/dmem_stage_ctrl_pkg.sv
// Shared types and default widths for the data-memory stage controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DUMP,
        HALTED
    } stateT;

    localparam int unsigned DefDataW   = 16;
    localparam int unsigned DefAddrW   = 16;
    localparam int unsigned DefNumFwd  = 2;
    localparam int unsigned DefTimeout = 63;

endpackage

// File: rtl/dmem_stage_ctrl_if.sv
// Memory-side bus between the stage controller (master) and the data memory (slave).
interface dmem_stage_ctrl_if
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
) ();

    logic              m_rd;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_done;
    logic              m_err;
    logic              m_dump;

    modport master (
        output m_rd, m_wr, m_addr, m_wdata, m_dump,
        input  m_rdata, m_done, m_err
    );

    modport slave (
        input  m_rd, m_wr, m_addr, m_wdata, m_dump,
        output m_rdata, m_done, m_err
    );

endinterface

// File: rtl/dmem_stage_ctrl_fwd_mux.sv
// N+1-way store-data select: sel 0 (or out of range) picks base, sel k picks source k-1.
module fwd_mux #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned SEL_W   = 2
) (
    input  logic [DATA_W-1:0]         base,
    input  logic [NUM_FWD*DATA_W-1:0] srcs,
    input  logic [SEL_W-1:0]          sel,
    output logic [DATA_W-1:0]         dataOut
);

    always_comb begin
        dataOut = base;
        for (int unsigned k = 0; k < NUM_FWD; k++) begin
            if (sel == SEL_W'(k + 1)) begin
                dataOut = srcs[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/dmem_stage_ctrl.sv
// Memory-stage controller: registered request issue, stall generation,
// alignment/timeout error detection and halt/dump sequencing.
module dmem_stage_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned NUM_FWD     = DefNumFwd,
    parameter int unsigned TIMEOUT     = DefTimeout,
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mem_read,
    input  logic                            mem_write,
    input  logic [ADDR_W-1:0]               addr,
    input  logic [DATA_W-1:0]               write_data,
    input  logic [NUM_FWD*DATA_W-1:0]       fwd_data,
    input  logic [$clog2(NUM_FWD+1)-1:0]    fwd_sel,
    input  logic                            halt_in,
    input  logic                            err_in,
    dmem_stage_ctrl_if.master               mem,
    output logic [DATA_W-1:0]               read_data,
    output logic                            pipe_go,
    output logic                            bubble_memwb,
    output logic                            err,
    output logic                            halted
);

    localparam int unsigned SelW = $clog2(NUM_FWD + 1);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    stateT             state;
    stateT             stateNext;
    logic              opRdQ;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] rdataQ;
    logic [CntW-1:0]   cntQ;
    logic              errQ;
    logic [DATA_W-1:0] fwdSelData;

    logic req;
    logic misaligned;
    logic doneOk;
    logic timeUp;
    logic issue;
    logic errSet;

    fwd_mux #(
        .DATA_W (DATA_W),
        .NUM_FWD(NUM_FWD),
        .SEL_W  (SelW)
    ) uFwdMux (
        .base   (write_data),
        .srcs   (fwd_data),
        .sel    (fwd_sel),
        .dataOut(fwdSelData)
    );

    assign req        = mem_read | mem_write;
    assign misaligned = (ALIGN_CHECK != 0) && addr[0] && req;
    assign doneOk     = mem.m_done & ~mem.m_err;
    assign timeUp     = (cntQ == CntW'(TIMEOUT));
    assign issue      = (state == IDLE) & ~halt_in & ~err_in & ~misaligned & req;

    // Halt outranks an alignment fault; a completion outranks a coincident timeout.
    always_comb begin
        errSet = 1'b0;
        case (state)
            IDLE:    errSet = err_in | (~halt_in & misaligned);
            BUSY:    errSet = mem.m_err | (~mem.m_done & timeUp);
            default: errSet = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (halt_in | err_in)  stateNext = DUMP;
                else if (misaligned)   stateNext = DUMP;
                else if (req)          stateNext = BUSY;
            end
            BUSY: begin
                if (mem.m_err)         stateNext = DUMP;
                else if (mem.m_done)   stateNext = IDLE;
                else if (timeUp)       stateNext = DUMP;
            end
            DUMP:    stateNext = HALTED;
            HALTED:  stateNext = HALTED;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opRdQ  <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            rdataQ <= '0;
            cntQ   <= '0;
            errQ   <= 1'b0;
        end else begin
            if (issue) begin
                opRdQ  <= mem_read;
                addrQ  <= addr;
                wdataQ <= fwdSelData;
                cntQ   <= '0;
            end else if (state == BUSY && !timeUp) begin
                cntQ <= cntQ + CntW'(1);
            end
            if (state == BUSY && doneOk && opRdQ) begin
                rdataQ <= mem.m_rdata;
            end
            if (errSet) begin
                errQ <= 1'b1;
            end
        end
    end

    // Strobes are forced low while rst is high so a dropped request never reaches memory.
    always_comb begin
        mem.m_rd    = 1'b0;
        mem.m_wr    = 1'b0;
        mem.m_dump  = 1'b0;
        mem.m_addr  = addrQ;
        mem.m_wdata = wdataQ;
        pipe_go     = 1'b0;
        halted      = 1'b0;
        read_data   = rdataQ;
        case (state)
            IDLE: pipe_go = ~halt_in & ~err_in & ~req;
            BUSY: begin
                mem.m_rd = opRdQ;
                mem.m_wr = ~opRdQ;
                pipe_go  = doneOk;
                if (doneOk && opRdQ) read_data = mem.m_rdata;
            end
            DUMP:    mem.m_dump = 1'b1;
            HALTED:  halted     = 1'b1;
            default: pipe_go    = 1'b0;
        endcase
        if (rst) begin
            mem.m_rd   = 1'b0;
            mem.m_wr   = 1'b0;
            mem.m_dump = 1'b0;
            pipe_go    = 1'b0;
            halted     = 1'b0;
        end
    end

    assign bubble_memwb = ~pipe_go;
    assign err          = errQ;

endmodule

// File: tb/tb_dmem_stage_ctrl.sv
// Randomised and directed bench for dmem_stage_ctrl with an in-bench behavioural model.
module tb_dmem_stage_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned NF = 2;
    localparam int unsigned TO = 3;
    localparam int unsigned SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              memRead;
    logic              memWrite;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     writeData;
    logic [NF*DW-1:0]  fwdData;
    logic [SW-1:0]     fwdSel;
    logic              haltIn;
    logic              errIn;
    logic [DW-1:0]     readData;
    logic              pipeGo;
    logic              bubble;
    logic              errO;
    logic              haltedO;

    dmem_stage_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();

    dmem_stage_ctrl #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .NUM_FWD    (NF),
        .TIMEOUT    (TO),
        .ALIGN_CHECK(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (memRead),
        .mem_write   (memWrite),
        .addr        (addr),
        .write_data  (writeData),
        .fwd_data    (fwdData),
        .fwd_sel     (fwdSel),
        .halt_in     (haltIn),
        .err_in      (errIn),
        .mem         (mif),
        .read_data   (readData),
        .pipe_go     (pipeGo),
        .bubble_memwb(bubble),
        .err         (errO),
        .halted      (haltedO)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding request, a wait count, and dump/halt flags.
    bit            mKnown = 1'b0;
    bit            mBusy, mDump, mHalt, mOpRd, mErr;
    int            mWait;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mData, mRd;

    function automatic logic [DW-1:0] pickStore(input logic [SW-1:0] s, input logic [DW-1:0] wd,
                                                input logic [NF*DW-1:0] fd);
        if (s == 2'd1) return fd[15:0];
        if (s == 2'd2) return fd[31:16];
        return wd;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b1) begin
                chk("rst_pipe_go", pipeGo, 0);
                chk("rst_bubble", bubble, 1);
                chk("rst_m_rd", mif.m_rd, 0);
                chk("rst_m_wr", mif.m_wr, 0);
                chk("rst_m_dump", mif.m_dump, 0);
                chk("rst_halted", haltedO, 0);
                mKnown = 1'b1;
                mBusy = 0; mDump = 0; mHalt = 0; mOpRd = 0; mErr = 0; mWait = 0;
                mAddr = '0; mData = '0; mRd = '0;
            end else if (mKnown) begin
                bit            eRd, eWr, eDump, eGo, eErr, eHalted, skipRd;
                logic [AW-1:0] eAddr;
                logic [DW-1:0] eWdata, eRdata;
                eRd = 0; eWr = 0; eDump = 0; eGo = 0; skipRd = 0;
                eErr = mErr; eHalted = mHalt; eAddr = mAddr; eWdata = mData; eRdata = mRd;
                if (mHalt) begin
                    eGo = 0;
                end else if (mDump) begin
                    eDump = 1; mDump = 0; mHalt = 1;
                end else if (mBusy) begin
                    eRd = mOpRd; eWr = !mOpRd;
                    if (mif.m_err) begin
                        skipRd = mif.m_done && mOpRd;
                        mErr = 1; mBusy = 0; mDump = 1;
                    end else if (mif.m_done) begin
                        eGo = 1;
                        if (mOpRd) begin eRdata = mif.m_rdata; mRd = mif.m_rdata; end
                        mBusy = 0;
                    end else if (mWait == int'(TO)) begin
                        mErr = 1; mBusy = 0; mDump = 1;
                    end else begin
                        mWait++;
                    end
                end else begin
                    if (haltIn || errIn) begin
                        mDump = 1;
                        if (errIn) mErr = 1;
                    end else if ((memRead || memWrite) && addr[0]) begin
                        mErr = 1; mDump = 1;
                    end else if (memRead || memWrite) begin
                        mBusy = 1; mWait = 0; mOpRd = memRead;
                        mAddr = addr; mData = pickStore(fwdSel, writeData, fwdData);
                    end else begin
                        eGo = 1;
                    end
                end
                chk("m_rd", mif.m_rd, eRd);
                chk("m_wr", mif.m_wr, eWr);
                chk("m_dump", mif.m_dump, eDump);
                chk("pipe_go", pipeGo, eGo);
                chk("bubble_memwb", bubble, !eGo);
                chk("err", errO, eErr);
                chk("halted", haltedO, eHalted);
                if (eRd || eWr) begin
                    chk("m_addr", mif.m_addr, eAddr);
                    chk("m_wdata", mif.m_wdata, eWdata);
                end
                if (!skipRd) chk("read_data", readData, eRdata);
            end
        end
    end

    task automatic drive(input bit r, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [SW-1:0] s, input bit h,
                         input bit e, input bit dn, input bit me, input logic [DW-1:0] rdat);
        @(negedge clk);
        rst = r; memRead = rd; memWrite = wr; addr = a; writeData = wd; fwdSel = s;
        haltIn = h; errIn = e; mif.m_done = dn; mif.m_err = me; mif.m_rdata = rdat;
    endtask

    task automatic idle(input bit dn = 0, input logic [DW-1:0] rdat = '0);
        drive(0, 0, 0, '0, '0, '0, 0, 0, dn, 0, rdat);
    endtask

    task automatic doReset();
        drive(1, 0, 0, '0, '0, '0, 0, 0, 0, 0, '0);
        drive(1, 0, 0, '0, '0, '0, 0, 0, 0, 0, '0);
    endtask

    initial begin
        fwdData = {16'h5678, 16'h1234};
        doReset();
        #2 chk("L_reset_go", pipeGo, 0);
        idle();
        #2 chk("L_reset_err", errO, 0);
        chk("L_reset_addr", mif.m_addr, 0);
        chk("L_reset_rdata", readData, 0);
        chk("L_idle_go", pipeGo, 1);

        // load with done in first BUSY cycle
        drive(0, 1, 0, 16'h0010, '0, '0, 0, 0, 0, 0, '0);
        #2 chk("L1_issue_go", pipeGo, 0);
        idle(1, 16'hBEEF);
        #2 chk("L1_done_go", pipeGo, 1);
        chk("L1_done_rd", mif.m_rd, 1);
        chk("L1_done_addr", mif.m_addr, 16'h0010);
        chk("L1_done_rdata", readData, 16'hBEEF);
        idle();
        #2 chk("L1_held_rdata", readData, 16'hBEEF);

        // forwarded store, store data sampled at issue only
        drive(0, 0, 1, 16'h0040, 16'hAAAA, 2'd1, 0, 0, 0, 0, '0);
        #2 chk("L2_issue_go", pipeGo, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 16'h9999, 16'h5555, 2'd2, 0, 0, (i == 4), 0, 16'h7777);
            #2 chk("L2_m_wr", mif.m_wr, 1);
            chk("L2_m_wdata", mif.m_wdata, 16'h1234);
            chk("L2_go", pipeGo, (i == 4));
            chk("L2_rdata", readData, 16'hBEEF);
        end
        idle();
        #2 chk("L2_after_rdata", readData, 16'hBEEF);

        // timeout after TO+1 BUSY cycles
        drive(0, 1, 0, 16'h0020, '0, '0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            idle();
            #2 chk("L3_busy_go", pipeGo, 0);
            chk("L3_busy_err", errO, 0);
        end
        idle();
        #2 chk("L3_dump", mif.m_dump, 1);
        chk("L3_err", errO, 1);
        idle();
        #2 chk("L3_dump_off", mif.m_dump, 0);
        chk("L3_halted", haltedO, 1);
        drive(0, 1, 0, 16'h0020, '0, '0, 0, 0, 0, 0, '0);
        #2 chk("L3_halt_go", pipeGo, 0);

        // misaligned read
        doReset();
        drive(0, 1, 0, 16'h0011, '0, '0, 0, 0, 0, 0, '0);
        #2 chk("L4_no_rd", mif.m_rd, 0);
        idle();
        #2 chk("L4_dump", mif.m_dump, 1);
        chk("L4_err", errO, 1);
        idle();
        #2 chk("L4_halted", haltedO, 1);

        // halt beats a simultaneous store
        doReset();
        drive(0, 0, 1, 16'h0030, 16'h4444, '0, 1, 0, 0, 0, '0);
        #2 chk("L5_go", pipeGo, 0);
        idle();
        #2 chk("L5_dump", mif.m_dump, 1);
        chk("L5_no_wr", mif.m_wr, 0);
        idle();
        #2 chk("L5_halted", haltedO, 1);
        chk("L5_err", errO, 0);

        // reset in the second BUSY cycle
        doReset();
        drive(0, 1, 0, 16'h0050, '0, '0, 0, 0, 0, 0, '0);
        idle();
        #2 chk("L6_busy_rd", mif.m_rd, 1);
        drive(1, 0, 0, '0, '0, '0, 0, 0, 0, 0, '0);
        drive(1, 0, 0, '0, '0, '0, 0, 0, 0, 0, '0);
        #2 chk("L6_rd_low", mif.m_rd, 0);
        chk("L6_go_low", pipeGo, 0);
        idle();
        #2 chk("L6_go_after", pipeGo, 1);

        for (int ep = 0; ep < 20; ep++) begin
            doReset();
            for (int c = 0; c < 150; c++) begin
                int unsigned r;
                logic [AW-1:0] a;
                bit rd, wr;
                r  = $urandom_range(0, 99);
                rd = (r < 25);
                wr = (r >= 25 && r < 50);
                a  = AW'($urandom) & ~AW'(1);
                if ($urandom_range(0, 24) == 0) a[0] = 1'b1;
                drive(($urandom_range(0, 149) == 0), rd, wr, a, DW'($urandom), SW'($urandom_range(0, 3)),
                      ($urandom_range(0, 59) == 0), ($urandom_range(0, 119) == 0),
                      ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 3), DW'($urandom));
                fwdData = {DW'($urandom), DW'($urandom)};
            end
        end

        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
